// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame constants and the baud divisor table.
// Used by uart_receiver, uart_baud_controller and the matching transmitter.
package uart_pkg;

    localparam int OVS_DEFAULT = 16;
    localparam int DATA_BITS   = 8;
    localparam int FRAME_BITS  = 11;  // start + 8 data + parity + stop

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // 3-bit baud_select code to bit rate
    function automatic int baud_rate(input logic [2:0] sel);
        int r;
        case (sel)
            3'd0:    r = 300;
            3'd1:    r = 1200;
            3'd2:    r = 4800;
            3'd3:    r = 9600;
            3'd4:    r = 19200;
            3'd5:    r = 38400;
            3'd6:    r = 57600;
            default: r = 115200;
        endcase
        return r;
    endfunction

    // Clock cycles per oversample tick, rounded to nearest
    function automatic int baud_divisor(input int clk_hz, input int ovs, input logic [2:0] sel);
        int den;
        den = ovs * baud_rate(sel);
        return (clk_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_baud_controller.sv
// Oversample tick generator. The divisor is captured from baud_sel_i on restart_i
// so that a frame keeps its rate even if the select input changes mid-frame;
// restart_i also zeroes the counter so ticks are phase-aligned to the start edge.
module uart_baud_controller
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int OVERSAMPLE  = OVS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_sel_i,
    input  logic       restart_i,
    output logic       tick_o
);

    localparam int CW = $clog2(baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, 3'd0) + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_q, div_d;
    logic          wrap;

    assign wrap   = (cnt_q >= div_q - CW'(1));
    assign tick_o = !restart_i && wrap;

    // Next count / divisor latch
    always_comb begin
        div_d = div_q;
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        if (restart_i) begin
            div_d = CW'(baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, baud_sel_i));
            cnt_d = '0;
        end
    end

    // Counter and divisor registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            div_q <= CW'(baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, 3'd0));
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB-first, even parity, one stop bit, 16x oversampling.
// Optional build macro RX_MAJORITY_VOTE_EN: each bit is the majority of ticks 7,8,9
// of the bit instead of the single tick-8 sample (strobes then land one tick later).
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int OVERSAMPLE  = OVS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       Rx_D,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    localparam int            TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID = TW'(OVERSAMPLE / 2 - 1);  // tick counter value on the mid-bit tick
    localparam logic [TW-1:0] TOP = TW'(OVERSAMPLE - 1);

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [2:0]           bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 armed_q, armed_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [1:0]           sync_q;
    logic                 line, tick, restart, decide, bit_s;

    assign line = sync_q[1];

    uart_baud_controller #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .OVERSAMPLE  (OVERSAMPLE)
    ) u_baud (
        .clk        (clk),
        .reset      (reset),
        .baud_sel_i (baud_select),
        .restart_i  (restart),
        .tick_o     (tick)
    );

`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [TW-1:0] DECIDE = MID + TW'(1);
    logic [1:0] vote_q;

    // Capture the two samples ahead of the deciding tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vote_q <= 2'b11;
        end else if (tick && tcnt_q == MID - TW'(1)) begin
            vote_q[0] <= line;
        end else if (tick && tcnt_q == MID) begin
            vote_q[1] <= line;
        end
    end

    assign bit_s = (vote_q[0] & vote_q[1]) | (vote_q[0] & line) | (vote_q[1] & line);
`else
    localparam logic [TW-1:0] DECIDE = MID;
    assign bit_s = line;
`endif

    assign decide = tick && (tcnt_q == DECIDE);

    // Frame FSM: next state, shift register and result strobes
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        armed_d = armed_q | line;  // any high cycle re-arms after a break
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        restart = 1'b0;
        if (tick) tcnt_d = (tcnt_q == TOP) ? '0 : tcnt_q + TW'(1);
        if (!Rx_EN) begin
            state_d = IDLE;  // abort without strobe, Rx_DATA untouched
        end else begin
            case (state_q)
                IDLE: if (armed_q && !line) begin
                    state_d = START;
                    restart = 1'b1;
                    tcnt_d  = '0;
                end
                START: if (decide) begin
                    state_d = bit_s ? IDLE : DATA;  // high at mid-start is a false start
                    bcnt_d  = '0;
                end
                DATA: if (decide) begin
                    shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: if (decide) begin
                    par_d   = bit_s;
                    state_d = STOP;
                end
                STOP: if (decide) begin
                    data_d  = shift_q;
                    perr_d  = ^{shift_q, par_q};
                    ferr_d  = !bit_s;
                    valid_d = !perr_d && bit_s;
                    if (!bit_s) armed_d = 1'b0;  // hold off until the line returns high
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            armed_q <= 1'b1;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            armed_q <= armed_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            sync_q  <= {sync_q[0], Rx_D};
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_PERROR = perr_q;
    assign Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver. A behavioural serial driver sends frames
// while a checker thread waits for the strobe and compares it against the queue.
// The DUT runs from a 12.5 MHz parameter so the 9600-baud frame stays short.
module tb_uart_receiver;

    localparam int CLK_HZ = 12_500_000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] baud_select = 3'd7;
    logic       Rx_EN = 1'b1;
    logic       Rx_D = 1'b1;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID, Rx_PERROR, Rx_FERROR;

    typedef struct {
        logic [7:0] data;
        logic       v;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    uart_receiver #(.CLK_FREQ_HZ(CLK_HZ), .OVERSAMPLE(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .Rx_EN       (Rx_EN),
        .Rx_D        (Rx_D),
        .Rx_DATA     (Rx_DATA),
        .Rx_VALID    (Rx_VALID),
        .Rx_PERROR   (Rx_PERROR),
        .Rx_FERROR   (Rx_FERROR)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, miscompares so far %0d", miscompares);
        $fatal(1, "watchdog expired");
    end

    // Bit period in clocks: 16 ticks of the rounded divisor
    function automatic int bit_len(input logic [2:0] sel);
        int baud;
        case (sel)
            3'd0:    baud = 300;
            3'd1:    baud = 1200;
            3'd2:    baud = 4800;
            3'd3:    baud = 9600;
            3'd4:    baud = 19200;
            3'd5:    baud = 38400;
            3'd6:    baud = 57600;
            default: baud = 115200;
        endcase
        return 16 * ((2 * CLK_HZ / (16 * baud) + 1) / 2);
    endfunction

    // Drive one 11-bit frame starting at a falling clock edge
    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop, input int bl);
        logic [10:0] f;
        f = {stop, (^d) ^ pflip, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            Rx_D = f[i];
            repeat (bl) @(negedge clk);
        end
    endtask

    task automatic expect_frame(input string name, input int budget);
        int   n;
        exp_t e;
        n = 0;
        while (!(Rx_VALID || Rx_PERROR || Rx_FERROR) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s: no strobe within %0d cycles, one expected", name, budget);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: strobe with empty scoreboard, data=%h v=%b pe=%b fe=%b",
                     name, Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR);
        end else begin
            e = exp_q.pop_front();
            if ({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR} !== {e.data, e.v, e.pe, e.fe}) begin
                miscompares++;
                $display("FAIL %s: got data=%h v=%b pe=%b fe=%b, want data=%h v=%b pe=%b fe=%b",
                         name, Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, e.data, e.v, e.pe, e.fe);
            end
            @(negedge clk);
            vectors++;
            if ({Rx_VALID, Rx_PERROR, Rx_FERROR} !== 3'b000) begin
                miscompares++;
                $display("FAIL %s_width: strobes %b one cycle later, want 000", name,
                         {Rx_VALID, Rx_PERROR, Rx_FERROR});
            end
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int hits;
        hits = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (Rx_VALID || Rx_PERROR || Rx_FERROR) hits++;
        end
        vectors++;
        if (hits !== 0) begin
            miscompares++;
            $display("FAIL %s: %0d strobe cycles seen, want 0", name, hits);
        end
    endtask

    task automatic good_frame(input string name, input logic [7:0] d);
        int bl;
        bl = bit_len(baud_select);
        exp_q.push_back('{data: d, v: 1'b1, pe: 1'b0, fe: 1'b0});
        fork
            send_frame(d, 1'b0, 1'b1, bl);
            expect_frame(name, 12 * bl);
        join
        repeat (bl) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset_held: got %h, want 000", {Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR});
        end
        reset = 1'b0;
        repeat (8) @(negedge clk);
        vectors++;
        if ({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset_release: got %h, want 000", {Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR});
        end
    endtask

    task automatic test_single();
        baud_select = 3'd7;
        good_frame("single_0F", 8'h0F);
    endtask

    task automatic test_back_to_back();
        int bl;
        bl = bit_len(3'd7);
        exp_q.push_back('{data: 8'hEA, v: 1'b1, pe: 1'b0, fe: 1'b0});
        exp_q.push_back('{data: 8'h0F, v: 1'b1, pe: 1'b0, fe: 1'b0});
        fork
            begin
                send_frame(8'hEA, 1'b0, 1'b1, bl);
                send_frame(8'h0F, 1'b0, 1'b1, bl);
            end
            begin
                expect_frame("b2b_EA", 12 * bl);
                expect_frame("b2b_0F", 12 * bl);
            end
        join
        repeat (bl) @(negedge clk);
    endtask

    // 9600 frame with flipped parity; baud_select moves mid-frame and must be ignored
    task automatic test_parity_error();
        int bl;
        baud_select = 3'd3;
        bl = bit_len(3'd3);
        exp_q.push_back('{data: 8'hA5, v: 1'b0, pe: 1'b1, fe: 1'b0});
        fork
            send_frame(8'hA5, 1'b1, 1'b1, bl);
            begin
                repeat (2 * bl) @(negedge clk);
                baud_select = 3'd7;
            end
            expect_frame("perror_A5", 12 * bl);
        join
        repeat (bl) @(negedge clk);
    endtask

    task automatic test_break();
        int bl;
        bl = bit_len(3'd7);
        exp_q.push_back('{data: 8'h3C, v: 1'b0, pe: 1'b0, fe: 1'b1});
        fork
            begin
                send_frame(8'h3C, 1'b0, 1'b0, bl);
                repeat (20 * bl) @(negedge clk);
                Rx_D = 1'b1;
                repeat (2 * bl) @(negedge clk);
            end
            begin
                expect_frame("ferror_3C", 12 * bl);
                expect_quiet("break_no_retrigger", 20 * bl);
            end
        join
        good_frame("after_break_55", 8'h55);
    endtask

    task automatic test_false_start();
        int bl;
        bl = bit_len(3'd7);
        Rx_D = 1'b0;
        repeat (bl / 3) @(negedge clk);
        Rx_D = 1'b1;
        expect_quiet("false_start", 3 * bl);
        good_frame("after_glitch_96", 8'h96);
    endtask

    task automatic test_reset_mid_frame();
        int bl;
        bl = bit_len(3'd7);
        fork
            send_frame(8'h81, 1'b0, 1'b1, bl);
            begin
                repeat (4 * bl) @(negedge clk);
                reset = 1'b1;
                #1;
                vectors++;
                if ({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR} !== 11'h0) begin
                    miscompares++;
                    $display("FAIL reset_mid: got %h, want 000",
                             {Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR});
                end
                repeat (8 * bl) @(negedge clk);
                reset = 1'b0;
            end
        join
        repeat (bl) @(negedge clk);
        good_frame("after_reset_81", 8'h81);
    endtask

    task automatic test_enable_abort();
        int bl;
        bl = bit_len(3'd7);
        fork
            send_frame(8'h42, 1'b0, 1'b1, bl);
            begin
                repeat (4 * bl) @(negedge clk);
                Rx_EN = 1'b0;
                expect_quiet("en_abort", 8 * bl);
            end
        join
        vectors++;
        if (Rx_DATA !== 8'h81) begin
            miscompares++;
            $display("FAIL en_abort_data: got %h, want 81", Rx_DATA);
        end
        Rx_EN = 1'b1;
        repeat (bl) @(negedge clk);
        good_frame("after_enable_42", 8'h42);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity_error();
        test_break();
        test_false_start();
        test_reset_mid_frame();
        test_enable_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
